// File: rtl/byte_cpu_pkg.sv
// Shared definitions for the byte processor: opcodes, instruction field
// positions and default widths.
package byte_cpu_pkg;

  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 3;
  localparam int NREGS_DEF = 8;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_XOR  = 2'b01;
  localparam logic [1:0] OP_BUFF = 2'b10;
  localparam logic [1:0] OP_LDI  = 2'b11;

  // Instruction layout: [15:14] op, [13:11] rd, [10:8] rs1, [7:5] rs2, [7:0] imm8
  localparam int OP_LSB  = 14;
  localparam int RD_LSB  = 11;
  localparam int RS1_LSB = 8;
  localparam int RS2_LSB = 5;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/byte_regfile.sv
// NREGS x DW register file: two asynchronous read ports, one synchronous
// write port, synchronous reset to zero. Reads see the old value on a write.
module byte_regfile
  import byte_cpu_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/byte_operand_stage.sv
// Operand-fetch/issue stage: decode, regfile read, RAW scoreboard and a
// valid/ready output register. Optional forwarding: BYTE_OPERAND_STAGE_BYPASS_EN.
//
// Handshake: a transfer happens on any rising edge where valid and ready are
// both high; once valid is raised the payload stays stable until that edge.
module byte_operand_stage
  import byte_cpu_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_op,
  output logic [AW-1:0] out_rd,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data
);

  logic [1:0]       dec_op;
  logic [AW-1:0]    dec_rd, dec_rs1, dec_rs2;
  logic [DW-1:0]    dec_imm;
  logic             uses_rs1, uses_rs2;
  logic [DW-1:0]    rf_a, rf_b, val_a, val_b;
  logic             pend_rs1, pend_rs2;
  logic             hazard, accept;
  logic [NREGS-1:0] pending, pending_nxt;

  assign dec_op   = in_instr[OP_LSB +: 2];
  assign dec_rd   = in_instr[RD_LSB +: AW];
  assign dec_rs1  = in_instr[RS1_LSB +: AW];
  assign dec_rs2  = in_instr[RS2_LSB +: AW];
  assign dec_imm  = in_instr[IMM_LSB +: DW];
  assign uses_rs1 = (dec_op != OP_LDI);
  assign uses_rs2 = (dec_op == OP_AND) || (dec_op == OP_XOR);

  byte_regfile #(.NREGS(NREGS), .AW(AW), .DW(DW)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (dec_rs1),
    .rdata_a (rf_a),
    .raddr_b (dec_rs2),
    .rdata_b (rf_b),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data)
  );

`ifdef BYTE_OPERAND_STAGE_BYPASS_EN
  // A same-cycle writeback both supplies the data and retires the hazard.
  logic byp_a, byp_b;
  assign byp_a    = wb_en && (wb_addr == dec_rs1);
  assign byp_b    = wb_en && (wb_addr == dec_rs2);
  assign val_a    = byp_a ? wb_data : rf_a;
  assign val_b    = byp_b ? wb_data : rf_b;
  assign pend_rs1 = pending[dec_rs1] && !byp_a;
  assign pend_rs2 = pending[dec_rs2] && !byp_b;
`else
  assign val_a    = rf_a;
  assign val_b    = rf_b;
  assign pend_rs1 = pending[dec_rs1];
  assign pend_rs2 = pending[dec_rs2];
`endif

  assign hazard   = (uses_rs1 && pend_rs1) || (uses_rs2 && pend_rs2);
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Set after clear so an issue to the register being written back stays pending.
  always_comb begin
    pending_nxt = pending;
    if (wb_en)  pending_nxt[wb_addr] = 1'b0;
    if (accept) pending_nxt[dec_rd]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_op    <= '0;
      out_rd    <= '0;
      out_a     <= '0;
      out_b     <= '0;
    end else begin
      pending <= pending_nxt;
      if (accept) begin
        out_valid <= 1'b1;
        out_op    <= dec_op;
        out_rd    <= dec_rd;
        out_a     <= (dec_op == OP_LDI) ? dec_imm : val_a;
        out_b     <= uses_rs2 ? val_b : '0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/byte_operand_stage.md
Name: byte_operand_stage

Overview:
- Operand-fetch/issue stage of the 3-stage byte processor. It sits directly upstream of the byte logic units (AND/XOR/BUFF) and feeds them.
- Decodes a 16-bit instruction and reads two 8-bit operands from an 8x8 register file.
- Tracks pending writes in a scoreboard to stall RAW hazards.
- Presents a/b/op/rd to the execute stage through a valid/ready output register. Execute results return via the writeback port.

Parameters:
- NREGS, 8, number of byte registers (power of 2).
- AW, 3, register address width (log2 NREGS).
- DW, 8, data width; matches the byte logic units' a/b/o.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage accepts instruction this cycle.
- in_instr  in  16  [15:14] opcode (00 AND, 01 XOR, 10 BUFF, 11 LDI); [13:11] rd; [10:8] rs1; [7:5] rs2; [7:0] imm8 (LDI only).
- out_valid  out  1  a/b/op/rd valid to execute.
- out_ready  in  1  execute consumes this cycle.
- out_op  out  2  opcode to execute.
- out_rd  out  AW  destination register.
- out_a  out  DW  operand a (rs1 value, or imm8 for LDI).
- out_b  out  DW  operand b (rs2 value; 0 for BUFF/LDI).
- wb_en  in  1  writeback strobe from execute/writeback.
- wb_addr  in  AW  writeback register.
- wb_data  in  DW  writeback byte (execute's o).

Behaviour:
- Reset (synchronous, active-high): regfile all 0x00, scoreboard pending[] all 0, out_valid=0, out_op=0, out_rd=0, out_a=0x00, out_b=0x00. in_ready may go high the cycle after rst deasserts.
- Accept condition: accept = in_valid & in_ready.
- in_ready = (!out_valid | out_ready) & !hazard.
- hazard: pending[rs1] for AND/XOR/BUFF, or pending[rs2] for AND/XOR, unless bypassed (see Optional Feature). LDI never hazards.
- Issue latency: 1 cycle. On accept, the output register loads on the next edge and out_valid=1.
- Output hold: while out_valid & !out_ready, out_* are held stable. Back-to-back issue at 1/cycle when out_ready=1.
- Consume: out_valid clears on out_ready with no new accept.
- Scoreboard: on accept, pending[rd] is set. On wb_en, pending[wb_addr] is cleared. If both hit the same address in one cycle, set wins.
- Regfile writes: on wb_en, regfile[wb_addr] is written. A read in the same cycle returns the old value, except under the bypass feature.
- Hazard on an unwritten register: the stall holds indefinitely until its writeback arrives. No timeout.
- Rising rst mid-stall or with out_valid=1: everything is flushed to reset values and the in-flight instruction is dropped.
- LDI: out_op=11, out_a=imm8, out_b=0. Execute passes it through as BUFF of a.

Optional Feature:
- Macro: BYTE_OPERAND_STAGE_BYPASS_EN.
- Defined: a wb_en in the same cycle whose wb_addr matches rs1/rs2 forwards wb_data into out_a/out_b. That pending bit is treated as cleared for the hazard check, so a dependent instruction issues in the writeback cycle.
- Undefined: no forwarding. The dependent instruction stalls until the cycle after wb_en, then reads the written regfile value.

Decomposition:
- Shared package byte_cpu_pkg holds:
  - opcode constants OP_AND=2'b00, OP_XOR=2'b01, OP_BUFF=2'b10, OP_LDI=2'b11;
  - instruction field bit positions;
  - DW/AW defaults.
- One natural sub-module: byte_regfile (NREGS x DW, 2 async read ports, 1 sync write port, sync reset to 0).
- Scoreboard and output register stay in the top module.

Test Plan:
1. Reset flush: assert rst for 2 cycles with in_valid=1 -> out_valid=0, out_a=out_b=0x00; in_ready=1 the first cycle after rst deasserts.
2. Back-to-back LDI: LDI r1,0x0F then LDI r2,0x0A, out_ready=1 -> out_a=0x0F then 0x0A, out_rd=1 then 2; pending[1], pending[2] set.
3. Writeback and operand read: wb r1=0x0F and r2=0x0A, then AND r3,r1,r2 -> out_op=00, out_a=0x0F, out_b=0x0A (execute yields 0x0A).
4. RAW stall: issue LDI r4,0x55 (pending), then XOR r5,r4,r1 -> in_ready=0 until wb r4. With the bypass macro, it issues in the wb cycle with out_a=0x55; without it, it issues one cycle later.
5. Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_* stable, in_ready=0; released on out_ready=1.
6. Collision: same-cycle accept of LDI r6 and wb_en to r6 -> pending[6] remains 1.
